// File: rtl/uart_param.sv
// uart_param: parametrised full-duplex UART with configurable data width, stop
// bits and RX oversampling. RX is 2-flop synchronised, glitch-filtered on the
// start bit, sampled at each bit centre, and reports framing errors.
// Optional feature macro: UART_PARITY_EN adds a parity bit after the data bits
// in both directions (even parity, or odd with PARITY_ODD=1).
module uart_param #(
  parameter int CLK_FREQ   = 50000000,
  parameter int BAUD       = 115200,
  parameter int DATA_BITS  = 8,
  parameter int STOP_BITS  = 1,
  parameter int OVERSAMPLE = 16,
  parameter int PARITY_ODD = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_send,
  output logic                 tx,
  output logic                 tx_busy,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_ok,
  output logic                 rx_frame_err,
  output logic                 rx_parity_err
);

  localparam int TXDIV      = (CLK_FREQ + BAUD / 2) / BAUD;
  localparam int RXDIV_CALC = (CLK_FREQ + BAUD * OVERSAMPLE / 2) / (BAUD * OVERSAMPLE);
  localparam int RXDIV      = (RXDIV_CALC < 1) ? 1 : RXDIV_CALC;
  localparam int TCW        = $clog2(STOP_BITS * TXDIV + 1);
  localparam int OSW        = $clog2(OVERSAMPLE);
  localparam int DVW        = (RXDIV > 1) ? $clog2(RXDIV) : 1;

  localparam logic [TCW-1:0] TX_BIT_END  = TCW'(TXDIV - 1);
  localparam logic [TCW-1:0] TX_STOP_END = TCW'(STOP_BITS * TXDIV - 1);
  localparam logic [OSW-1:0] OS_HALF_END = OSW'(OVERSAMPLE / 2 - 1);
  localparam logic [OSW-1:0] OS_FULL_END = OSW'(OVERSAMPLE - 1);
  localparam logic [DVW-1:0] DIV_END     = DVW'(RXDIV - 1);
  localparam logic [3:0]     LAST_BIT    = 4'(DATA_BITS - 1);

  // Shared state encoding for the TX and RX FSMs.
  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_START     = 3'd1;
  localparam logic [2:0] S_DATA      = 3'd2;
`ifdef UART_PARITY_EN
  localparam logic [2:0] S_PARITY    = 3'd3;
  localparam logic       PAR_ODD     = (PARITY_ODD != 0);
`endif
  localparam logic [2:0] S_STOP      = 3'd4;
  localparam logic [2:0] S_WAIT_HIGH = 3'd5;

  // Elaboration-time guard against unsupported parameter values.
  if (DATA_BITS < 5 || DATA_BITS > 9 || (STOP_BITS != 1 && STOP_BITS != 2) ||
      OVERSAMPLE < 4 || (OVERSAMPLE % 2) != 0 || PARITY_ODD < 0 || PARITY_ODD > 1)
  begin : g_bad_params
    $error("uart_param: unsupported parameter value");
  end

  // ---------------------------------------------------------------- TX
  logic [2:0]           tx_state_q, tx_state_d;
  logic [TCW-1:0]       tx_cnt_q, tx_cnt_d;
  logic [3:0]           tx_bit_q, tx_bit_d;
  logic [DATA_BITS-1:0] tx_shift_q, tx_shift_d;
  logic                 tx_q, tx_d;
`ifdef UART_PARITY_EN
  logic                 tx_par_q, tx_par_d;
`endif

  // TX next-state: every line bit is held for exactly TXDIV clocks.
  // NOTE: each variable gets a default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    tx_bit_d   = tx_bit_q;
    tx_shift_d = tx_shift_q;
    tx_d       = tx_q;
`ifdef UART_PARITY_EN
    tx_par_d   = tx_par_q;
`endif
    case (tx_state_q)
      S_IDLE: begin
        if (tx_send) begin
          tx_state_d = S_START;
          tx_cnt_d   = '0;
          tx_bit_d   = '0;
          tx_shift_d = tx_data;
          tx_d       = 1'b0;
`ifdef UART_PARITY_EN
          tx_par_d   = (^tx_data) ^ PAR_ODD;
`endif
        end
      end
      S_START: begin
        if (tx_cnt_q == TX_BIT_END) begin
          tx_state_d = S_DATA;
          tx_cnt_d   = '0;
          tx_d       = tx_shift_q[0];
          tx_shift_d = tx_shift_q >> 1;
        end else begin
          tx_cnt_d = tx_cnt_q + 1'b1;
        end
      end
      S_DATA: begin
        if (tx_cnt_q == TX_BIT_END) begin
          tx_cnt_d = '0;
          if (tx_bit_q == LAST_BIT) begin
`ifdef UART_PARITY_EN
            tx_state_d = S_PARITY;
            tx_d       = tx_par_q;
`else
            tx_state_d = S_STOP;
            tx_d       = 1'b1;
`endif
          end else begin
            tx_bit_d   = tx_bit_q + 1'b1;
            tx_d       = tx_shift_q[0];
            tx_shift_d = tx_shift_q >> 1;
          end
        end else begin
          tx_cnt_d = tx_cnt_q + 1'b1;
        end
      end
`ifdef UART_PARITY_EN
      S_PARITY: begin
        if (tx_cnt_q == TX_BIT_END) begin
          tx_state_d = S_STOP;
          tx_cnt_d   = '0;
          tx_d       = 1'b1;
        end else begin
          tx_cnt_d = tx_cnt_q + 1'b1;
        end
      end
`endif
      S_STOP: begin
        // Whole stop period is one count so two stop bits need no extra state.
        if (tx_cnt_q == TX_STOP_END) begin
          tx_state_d = S_IDLE;
          tx_cnt_d   = '0;
        end else begin
          tx_cnt_d = tx_cnt_q + 1'b1;
        end
      end
      default: begin
        tx_state_d = S_IDLE;
        tx_cnt_d   = '0;
        tx_d       = 1'b1;
      end
    endcase
  end

  // TX state registers; the line idles high.
  // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_state_q <= S_IDLE;
      tx_cnt_q   <= '0;
      tx_bit_q   <= '0;
      tx_shift_q <= '0;
      tx_q       <= 1'b1;
`ifdef UART_PARITY_EN
      tx_par_q   <= 1'b0;
`endif
    end else begin
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_bit_q   <= tx_bit_d;
      tx_shift_q <= tx_shift_d;
      tx_q       <= tx_d;
`ifdef UART_PARITY_EN
      tx_par_q   <= tx_par_d;
`endif
    end
  end

  assign tx      = tx_q;
  assign tx_busy = (tx_state_q != S_IDLE);

  // ---------------------------------------------------------------- RX
  logic [1:0]           rx_sync_q;
  logic                 rx_prev_q;
  logic                 rx_s, rx_fall, rx_tick;
  logic [2:0]           rx_state_q, rx_state_d;
  logic [DVW-1:0]       rx_div_q, rx_div_d;
  logic [OSW-1:0]       rx_os_q, rx_os_d;
  logic [3:0]           rx_bit_q, rx_bit_d;
  logic [DATA_BITS-1:0] rx_shift_q, rx_shift_d;
  logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
  logic                 rx_ok_q, rx_ok_d;
  logic                 rx_ferr_q, rx_ferr_d;
`ifdef UART_PARITY_EN
  logic                 rx_par_q, rx_par_d;
  logic                 rx_perr_q, rx_perr_d;
`endif

  // Two-flop synchroniser plus previous-value flop for falling-edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_sync_q <= 2'b11;
      rx_prev_q <= 1'b1;
    end else begin
      rx_sync_q <= {rx_sync_q[0], rx};
      rx_prev_q <= rx_sync_q[1];
    end
  end

  assign rx_s    = rx_sync_q[1];
  assign rx_fall = rx_prev_q & ~rx_s;
  assign rx_tick = (rx_div_q == DIV_END);

  // RX next-state: qualify the start bit at half a bit, then sample every bit centre.
  always_comb begin
    rx_state_d = rx_state_q;
    rx_div_d   = rx_tick ? '0 : rx_div_q + 1'b1;
    rx_os_d    = rx_os_q;
    rx_bit_d   = rx_bit_q;
    rx_shift_d = rx_shift_q;
    rx_data_d  = rx_data_q;
    rx_ok_d    = 1'b0;
    rx_ferr_d  = rx_ferr_q;
`ifdef UART_PARITY_EN
    rx_par_d   = rx_par_q;
    rx_perr_d  = rx_perr_q;
`endif
    case (rx_state_q)
      S_IDLE: begin
        rx_div_d = '0;
        if (rx_fall) begin
          rx_state_d = S_START;
          rx_os_d    = '0;
        end
      end
      S_START: begin
        if (rx_tick) begin
          if (rx_os_q == OS_HALF_END) begin
            rx_os_d    = '0;
            rx_bit_d   = '0;
            rx_state_d = rx_s ? S_IDLE : S_DATA;
          end else begin
            rx_os_d = rx_os_q + 1'b1;
          end
        end
      end
      S_DATA: begin
        if (rx_tick) begin
          if (rx_os_q == OS_FULL_END) begin
            rx_os_d    = '0;
            rx_shift_d = {rx_s, rx_shift_q[DATA_BITS-1:1]};
            if (rx_bit_q == LAST_BIT) begin
`ifdef UART_PARITY_EN
              rx_state_d = S_PARITY;
`else
              rx_state_d = S_STOP;
`endif
            end else begin
              rx_bit_d = rx_bit_q + 1'b1;
            end
          end else begin
            rx_os_d = rx_os_q + 1'b1;
          end
        end
      end
`ifdef UART_PARITY_EN
      S_PARITY: begin
        if (rx_tick) begin
          if (rx_os_q == OS_FULL_END) begin
            rx_os_d    = '0;
            rx_par_d   = rx_s;
            rx_state_d = S_STOP;
          end else begin
            rx_os_d = rx_os_q + 1'b1;
          end
        end
      end
`endif
      S_STOP: begin
        if (rx_tick) begin
          if (rx_os_q == OS_FULL_END) begin
            rx_os_d    = '0;
            rx_data_d  = rx_shift_q;
            rx_ferr_d  = ~rx_s;
            rx_ok_d    = 1'b1;
`ifdef UART_PARITY_EN
            rx_perr_d  = rx_par_q ^ (^rx_shift_q) ^ PAR_ODD;
`endif
            // A low stop bit (break) must see the line return high before re-arming.
            rx_state_d = rx_s ? S_IDLE : S_WAIT_HIGH;
          end else begin
            rx_os_d = rx_os_q + 1'b1;
          end
        end
      end
      S_WAIT_HIGH: begin
        rx_div_d = '0;
        if (rx_s) rx_state_d = S_IDLE;
      end
      default: begin
        rx_state_d = S_IDLE;
        rx_div_d   = '0;
      end
    endcase
  end

  // RX state and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_state_q <= S_IDLE;
      rx_div_q   <= '0;
      rx_os_q    <= '0;
      rx_bit_q   <= '0;
      rx_shift_q <= '0;
      rx_data_q  <= '0;
      rx_ok_q    <= 1'b0;
      rx_ferr_q  <= 1'b0;
`ifdef UART_PARITY_EN
      rx_par_q   <= 1'b0;
      rx_perr_q  <= 1'b0;
`endif
    end else begin
      rx_state_q <= rx_state_d;
      rx_div_q   <= rx_div_d;
      rx_os_q    <= rx_os_d;
      rx_bit_q   <= rx_bit_d;
      rx_shift_q <= rx_shift_d;
      rx_data_q  <= rx_data_d;
      rx_ok_q    <= rx_ok_d;
      rx_ferr_q  <= rx_ferr_d;
`ifdef UART_PARITY_EN
      rx_par_q   <= rx_par_d;
      rx_perr_q  <= rx_perr_d;
`endif
    end
  end

  assign rx_data      = rx_data_q;
  assign rx_ok        = rx_ok_q;
  assign rx_frame_err = rx_ferr_q;
`ifdef UART_PARITY_EN
  assign rx_parity_err = rx_perr_q;
`else
  assign rx_parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_param.sv
// tb_uart_param: directed bench for uart_param at CLK_FREQ=1.6 MHz, BAUD=100 kHz
// (TXDIV=16, RXDIV=1). Covers reset, TX framing, loopback, framing error/break,
// start-bit glitch rejection, busy-ignore, mid-frame reset, and parity when
// UART_PARITY_EN is defined.
module tb_uart_param;

`ifdef UART_PARITY_EN
  localparam logic HAS_PAR    = 1'b1;
  localparam int   FRAME_BITS = 11;
`else
  localparam logic HAS_PAR    = 1'b0;
  localparam int   FRAME_BITS = 10;
`endif
  localparam int BIT_CLKS = 16;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] tx_data;
  logic       tx_send;
  logic       tx;
  logic       tx_busy;
  logic       rx;
  logic       rx_drv;
  logic       loop_en;
  logic [7:0] rx_data;
  logic       rx_ok;
  logic       rx_frame_err;
  logic       rx_parity_err;

  int n_checks = 0;
  int n_fail   = 0;
  int ok_cnt   = 0;
  int err_cnt  = 0;
  logic [7:0] rx_log[$];

  always #5 clk = ~clk;

  assign rx = loop_en ? tx : rx_drv;

  uart_param #(
    .CLK_FREQ  (1600000),
    .BAUD      (100000),
    .DATA_BITS (8),
    .STOP_BITS (1),
    .OVERSAMPLE(16),
    .PARITY_ODD(0)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .tx_data      (tx_data),
    .tx_send      (tx_send),
    .tx           (tx),
    .tx_busy      (tx_busy),
    .rx           (rx),
    .rx_data      (rx_data),
    .rx_ok        (rx_ok),
    .rx_frame_err (rx_frame_err),
    .rx_parity_err(rx_parity_err)
  );

  // Receive monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (rx_ok) begin
      ok_cnt++;
      rx_log.push_back(rx_data);
      if (rx_frame_err || rx_parity_err) err_cnt++;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: observed 0x%0h, required 0x%0h", tag, got, exp);
    end
  endtask

  // Expected line level for bit position idx of a frame carrying d.
  function automatic logic line_bit(input logic [7:0] d, input int idx);
    if (idx == 0) return 1'b0;
    if (idx <= 8) return d[idx-1];
    if (HAS_PAR && idx == 9) return ^d;
    return 1'b1;
  endfunction

  task automatic send_tx(input logic [7:0] d);
    @(negedge clk);
    tx_data = d;
    tx_send = 1'b1;
    @(posedge clk);
    #1 tx_send = 1'b0;
  endtask

  task automatic wait_tx_idle(input string tag);
    int n = 0;
    while (tx_busy && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 1000) check(tag, 32'(tx_busy), 32'd0);
  endtask

  // Drive a serial frame on rx_drv; stop and parity levels are forced by the caller.
  task automatic drive_rx(input logic [7:0] d, input logic stop_v, input logic par_v);
    for (int idx = 0; idx < FRAME_BITS; idx++) begin
      logic v;
      v = line_bit(d, idx);
      if (HAS_PAR && idx == 9) v = par_v;
      if (idx == FRAME_BITS - 1) v = stop_v;
      @(negedge clk);
      rx_drv = v;
      repeat (BIT_CLKS - 1) @(negedge clk);
    end
  endtask

  initial begin
    #(10 * 90000);
    $display("FAIL watchdog: observed timeout, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int base;
    int busy_cnt;
    int unstable;
    int mism;
    int bad;
    logic obs [FRAME_BITS];

    rst_n   = 1'b0;
    tx_data = 8'h00;
    tx_send = 1'b0;
    rx_drv  = 1'b1;
    loop_en = 1'b0;

    // Reset values
    repeat (3) @(negedge clk);
    check("rst_tx", 32'(tx), 32'd1);
    check("rst_busy", 32'(tx_busy), 32'd0);
    check("rst_rx_ok", 32'(rx_ok), 32'd0);
    check("rst_rx_data", 32'(rx_data), 32'd0);
    check("rst_frame_err", 32'(rx_frame_err), 32'd0);
    check("rst_parity_err", 32'(rx_parity_err), 32'd0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    // T1: TX frame 0xA5, every bit held 16 clocks
    send_tx(8'hA5);
    busy_cnt = 0;
    unstable = 0;
    for (int k = 0; k < FRAME_BITS * BIT_CLKS; k++) begin
      @(negedge clk);
      if (tx !== line_bit(8'hA5, k / BIT_CLKS)) unstable++;
      if ((k % BIT_CLKS) == BIT_CLKS / 2) obs[k / BIT_CLKS] = tx;
      if (tx_busy) busy_cnt++;
    end
    for (int b = 0; b < FRAME_BITS; b++)
      check($sformatf("t1_bit%0d", b), 32'(obs[b]), 32'(line_bit(8'hA5, b)));
    check("t1_tx_bit_errors", 32'(unstable), 32'd0);
    check("t1_busy_clks", 32'(busy_cnt), 32'(FRAME_BITS * BIT_CLKS));
    @(negedge clk);
    check("t1_busy_after", 32'(tx_busy), 32'd0);
    check("t1_tx_after", 32'(tx), 32'd1);

    // T2: loopback of 0x00..0xFF, back-to-back
    loop_en = 1'b1;
    repeat (20) @(negedge clk);
    base = ok_cnt;
    begin
      int e0;
      e0 = err_cnt;
      for (int i = 0; i < 256; i++) begin
        @(negedge clk);
        wait_tx_idle("t2_tx_idle_timeout");
        tx_data = 8'(i);
        tx_send = 1'b1;
        @(posedge clk);
        #1 tx_send = 1'b0;
      end
      begin
        int n = 0;
        while (ok_cnt - base < 256 && n < 400) begin
          @(negedge clk);
          n++;
        end
      end
      check("t2_rx_count", 32'(ok_cnt - base), 32'd256);
      mism = 0;
      for (int i = 0; i < 256; i++)
        if (base + i >= rx_log.size() || rx_log[base + i] !== 8'(i)) mism++;
      check("t2_data_mismatches", 32'(mism), 32'd0);
      check("t2_err_frames", 32'(err_cnt - e0), 32'd0);
    end
    wait_tx_idle("t2_final_idle_timeout");
    loop_en = 1'b0;
    repeat (20) @(negedge clk);

    // T3: frame 0x3C with low stop bit, then line held low (break)
    base = ok_cnt;
    drive_rx(8'h3C, 1'b0, ^8'h3C);
    repeat (40) @(negedge clk);
    check("t3_one_rx_ok", 32'(ok_cnt - base), 32'd1);
    check("t3_rx_data", 32'(rx_data), 32'h3C);
    check("t3_frame_err", 32'(rx_frame_err), 32'd1);
    rx_drv = 1'b1;
    repeat (40) @(negedge clk);
    check("t3_no_rearm", 32'(ok_cnt - base), 32'd1);

    // T4: 4-clock low glitch rejected, following 0x55 frame received
    base = ok_cnt;
    rx_drv = 1'b0;
    repeat (4) @(negedge clk);
    rx_drv = 1'b1;
    repeat (60) @(negedge clk);
    check("t4_glitch_no_ok", 32'(ok_cnt - base), 32'd0);
    drive_rx(8'h55, 1'b1, ^8'h55);
    repeat (20) @(negedge clk);
    check("t4_rx_ok", 32'(ok_cnt - base), 32'd1);
    check("t4_rx_data", 32'(rx_data), 32'h55);
    check("t4_frame_err", 32'(rx_frame_err), 32'd0);

    // T5a: tx_send during a busy frame is ignored
    loop_en = 1'b1;
    repeat (20) @(negedge clk);
    base = ok_cnt;
    send_tx(8'h11);
    busy_cnt = 0;
    for (int k = 0; k < 240; k++) begin
      @(negedge clk);
      if (tx_busy) busy_cnt++;
      tx_send = (k == 49);
      tx_data = (k == 49) ? 8'h99 : 8'h11;
    end
    tx_send = 1'b0;
    check("t5_busy_clks", 32'(busy_cnt), 32'(FRAME_BITS * BIT_CLKS));
    check("t5_one_frame", 32'(ok_cnt - base), 32'd1);
    check("t5_rx_data", 32'(rx_data), 32'h11);

    // T5b: reset at clock 80 of a frame aborts both directions
    base = ok_cnt;
    send_tx(8'h5A);
    repeat (79) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("t5_rst_tx", 32'(tx), 32'd1);
    check("t5_rst_busy", 32'(tx_busy), 32'd0);
    bad = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (tx !== 1'b1 || tx_busy !== 1'b0 || rx_ok !== 1'b0) bad++;
    end
    check("t5_rst_hold_errors", 32'(bad), 32'd0);
    check("t5_rst_rx_data", 32'(rx_data), 32'd0);
    rst_n = 1'b1;
    repeat (300) @(negedge clk);
    check("t5_no_partial_ok", 32'(ok_cnt - base), 32'd0);
    check("t5_idle_after_rst", 32'(tx_busy), 32'd0);
    loop_en = 1'b0;
    repeat (10) @(negedge clk);

`ifdef UART_PARITY_EN
    // T6: even parity; 0x07 has three ones so parity bit is 1
    send_tx(8'h07);
    repeat (9 * BIT_CLKS + BIT_CLKS / 2 + 1) @(negedge clk);
    check("t6_tx_parity", 32'(tx), 32'd1);
    wait_tx_idle("t6_tx_idle_timeout");
    base = ok_cnt;
    drive_rx(8'h07, 1'b1, 1'b0);
    repeat (20) @(negedge clk);
    check("t6_rx_ok", 32'(ok_cnt - base), 32'd1);
    check("t6_rx_data", 32'(rx_data), 32'h07);
    check("t6_parity_err", 32'(rx_parity_err), 32'd1);
    check("t6_frame_err", 32'(rx_frame_err), 32'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
